// File: rtl/usb_uart.sv
// usb_uart: FTDI-facing 8N1 UART behind the CTRL/STAT/DATA register strobes.
//   clk, resetn           : 48 MHz clock, synchronous active-low reset
//   reg_d_i/reg_d_o       : register write data / combinational read data
//   reg_wr_i/reg_rd_i     : one-cycle write / read strobes (read only pops DATA)
//   reg_cs_ctrl/stat/data : register selects
//   uart_rx_i, cts_n_i    : asynchronous inputs from the FTDI chip
//   uart_tx_o, rts_n_o    : serial out (idle high), RX-side flow control
//   irq_o                 : registered interrupt request
module usb_uart #(
    parameter int FIFO_AW = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] reg_d_i,
    output logic [7:0] reg_d_o,
    input  logic       reg_wr_i,
    input  logic       reg_rd_i,
    input  logic       reg_cs_ctrl_i,
    input  logic       reg_cs_stat_i,
    input  logic       reg_cs_data_i,
    input  logic       uart_rx_i,
    output logic       uart_tx_o,
    input  logic       cts_n_i,
    output logic       rts_n_o,
    output logic       irq_o
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW+1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    function automatic logic [12:0] baud_div(input logic [2:0] sel);
        case (sel)
            3'd0:    return 13'd5000;
            3'd1:    return 13'd2500;
            3'd2:    return 13'd1250;
            3'd3:    return 13'd833;
            3'd4:    return 13'd416;
            3'd5:    return 13'd208;
            3'd6:    return 13'd104;
            default: return 13'd52;
        endcase
    endfunction

    // ---------------- register strobes / CTRL ----------------
    logic [2:0] baud;
    logic       fc_en, rx_ie, tx_ie;
    logic       wr_ctrl, wr_stat, wr_data, rd_data, flush;

    assign wr_ctrl = reg_wr_i & reg_cs_ctrl_i;
    assign wr_stat = reg_wr_i & reg_cs_stat_i;
    assign wr_data = reg_wr_i & reg_cs_data_i;
    assign rd_data = reg_rd_i & reg_cs_data_i;
    assign flush   = wr_ctrl & reg_d_i[7];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            baud  <= 3'd4;
            fc_en <= 1'b0;
            rx_ie <= 1'b0;
            tx_ie <= 1'b0;
        end else if (wr_ctrl) begin
            baud  <= reg_d_i[2:0];
            fc_en <= reg_d_i[4];
            rx_ie <= reg_d_i[5];
            tx_ie <= reg_d_i[6];
        end
    end

    // ---------------- synchronizers ----------------
    logic rx_s1, rx_s2, rx_prev, cts_s1, cts_s2;
    always_ff @(posedge clk) begin
        if (!resetn) begin
            {rx_s1, rx_s2, rx_prev} <= 3'b111;
            {cts_s1, cts_s2}        <= 2'b11;
        end else begin
            {rx_prev, rx_s2, rx_s1} <= {rx_s2, rx_s1, uart_rx_i};
            {cts_s2, cts_s1}        <= {cts_s1, cts_n_i};
        end
    end

    // ---------------- TX FIFO ----------------
    logic [7:0]         tx_mem [DEPTH];
    logic [FIFO_AW-1:0] tx_wp, tx_rp;
    logic [FIFO_AW:0]   tx_lvl;
    logic               tx_empty, tx_full, tx_push, tx_pop;

    assign tx_empty = (tx_lvl == '0);
    assign tx_full  = (tx_lvl == DEPTH_C);
    assign tx_push  = wr_data & (~tx_full | tx_pop);

    always_ff @(posedge clk) if (tx_push) tx_mem[tx_wp] <= reg_d_i;

    always_ff @(posedge clk) begin
        if (!resetn || flush) begin
            tx_wp <= '0; tx_rp <= '0; tx_lvl <= '0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + 1'b1;
            if (tx_pop)  tx_rp <= tx_rp + 1'b1;
            tx_lvl <= tx_lvl + {{FIFO_AW{1'b0}}, tx_push} - {{FIFO_AW{1'b0}}, tx_pop};
        end
    end

    // ---------------- TX FSM ----------------
    state_t      tx_state, tx_next;
    logic [12:0] tx_tmr, tx_div;
    logic [2:0]  tx_bit;
    logic [7:0]  tx_shift;
    logic        tx_last, tx_ready;

    assign tx_last  = (tx_tmr == tx_div - 13'd1);
    assign tx_ready = ~tx_empty & (~fc_en | ~cts_s2);

    // A new frame may start from IDLE or straight out of a finished stop
    // bit, so back-to-back frames leave no idle gap on the line.
    always_comb begin
        tx_next = tx_state;
        tx_pop  = 1'b0;
        case (tx_state)
            S_IDLE:  if (tx_ready) tx_next = S_START;
            S_START: if (tx_last) tx_next = S_DATA;
            S_DATA:  if (tx_last && tx_bit == 3'd7) tx_next = S_STOP;
            S_STOP:  if (tx_last) tx_next = tx_ready ? S_START : S_IDLE;
            default: tx_next = S_IDLE;
        endcase
        tx_pop = tx_ready & ((tx_state == S_IDLE) | ((tx_state == S_STOP) & tx_last));
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            tx_state <= S_IDLE;
            tx_tmr   <= '0;
            tx_div   <= '0;
            tx_bit   <= '0;
            tx_shift <= 8'hFF;
        end else begin
            tx_state <= tx_next;
            if (tx_pop) begin
                tx_shift <= tx_mem[tx_rp];
                tx_div   <= baud_div(baud);
                tx_tmr   <= '0;
                tx_bit   <= '0;
            end else if (tx_state != S_IDLE) begin
                if (tx_last) begin
                    tx_tmr <= '0;
                    if (tx_state == S_DATA) begin
                        tx_shift <= {1'b1, tx_shift[7:1]};
                        tx_bit   <= tx_bit + 3'd1;
                    end
                end else begin
                    tx_tmr <= tx_tmr + 13'd1;
                end
            end
        end
    end

    always_comb begin
        uart_tx_o = 1'b1;
        if (tx_state == S_START)     uart_tx_o = 1'b0;
        else if (tx_state == S_DATA) uart_tx_o = tx_shift[0];
    end

    // ---------------- RX FSM ----------------
    state_t      rx_state, rx_next;
    logic [12:0] rx_tmr, rx_div;
    logic [2:0]  rx_bit;
    logic [7:0]  rx_shift;
    logic        rx_mid_start, rx_mid_bit, rx_push_req, rx_ferr_set;

    assign rx_mid_start = (rx_tmr == (rx_div >> 1) - 13'd1);
    assign rx_mid_bit   = (rx_tmr == rx_div - 13'd1);

    always_comb begin
        rx_next     = rx_state;
        rx_push_req = 1'b0;
        rx_ferr_set = 1'b0;
        case (rx_state)
            S_IDLE:  if (rx_prev && !rx_s2) rx_next = S_START;
            S_START: if (rx_mid_start) rx_next = rx_s2 ? S_IDLE : S_DATA;
            S_DATA:  if (rx_mid_bit && rx_bit == 3'd7) rx_next = S_STOP;
            S_STOP: if (rx_mid_bit) begin
                rx_next     = S_IDLE;
                rx_push_req = rx_s2;
                rx_ferr_set = ~rx_s2;
            end
            default: rx_next = S_IDLE;
        endcase
    end

    // After the mid-start sample the timer restarts, so every later sample
    // lands at mid-bit, one full divisor apart.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rx_state <= S_IDLE;
            rx_tmr   <= '0;
            rx_div   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            rx_state <= rx_next;
            case (rx_state)
                S_IDLE: begin
                    rx_tmr <= '0;
                    rx_bit <= '0;
                    if (rx_prev && !rx_s2) rx_div <= baud_div(baud);
                end
                S_START: rx_tmr <= rx_mid_start ? 13'd0 : rx_tmr + 13'd1;
                S_DATA: begin
                    if (rx_mid_bit) begin
                        rx_tmr   <= '0;
                        rx_shift <= {rx_s2, rx_shift[7:1]};
                        rx_bit   <= rx_bit + 3'd1;
                    end else begin
                        rx_tmr <= rx_tmr + 13'd1;
                    end
                end
                default: rx_tmr <= rx_tmr + 13'd1;
            endcase
        end
    end

    // ---------------- RX FIFO ----------------
    logic [7:0]         rx_mem [DEPTH];
    logic [FIFO_AW-1:0] rx_wp, rx_rp;
    logic [FIFO_AW:0]   rx_lvl;
    logic               rx_empty, rx_full, rx_push, rx_pop, rx_ovf_set;

    assign rx_empty   = (rx_lvl == '0);
    assign rx_full    = (rx_lvl == DEPTH_C);
    assign rx_pop     = rd_data & ~rx_empty;
    assign rx_push    = rx_push_req & (~rx_full | rx_pop);
    assign rx_ovf_set = rx_push_req & rx_full & ~rx_pop;

    always_ff @(posedge clk) if (rx_push) rx_mem[rx_wp] <= rx_shift;

    always_ff @(posedge clk) begin
        if (!resetn || flush) begin
            rx_wp <= '0; rx_rp <= '0; rx_lvl <= '0;
        end else begin
            if (rx_push) rx_wp <= rx_wp + 1'b1;
            if (rx_pop)  rx_rp <= rx_rp + 1'b1;
            rx_lvl <= rx_lvl + {{FIFO_AW{1'b0}}, rx_push} - {{FIFO_AW{1'b0}}, rx_pop};
        end
    end

    // ---------------- sticky status, RTS, IRQ ----------------
    logic rx_ovf, rx_ferr, tx_ovf;
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rx_ovf  <= 1'b0;
            rx_ferr <= 1'b0;
            tx_ovf  <= 1'b0;
            rts_n_o <= 1'b0;
            irq_o   <= 1'b0;
        end else begin
            // a new event in the clearing cycle wins over the clear
            rx_ovf  <= (rx_ovf  & ~(wr_stat & reg_d_i[2])) | rx_ovf_set;
            rx_ferr <= (rx_ferr & ~(wr_stat & reg_d_i[3])) | rx_ferr_set;
            tx_ovf  <= (tx_ovf  & ~(wr_stat & reg_d_i[7])) | (wr_data & tx_full & ~tx_pop);
            rts_n_o <= (rx_lvl >= DEPTH_C - (FIFO_AW+1)'(4));
            irq_o   <= (rx_ie & ~rx_empty) | (tx_ie & tx_empty);
        end
    end

    // ---------------- read mux ----------------
    always_comb begin
        reg_d_o = 8'h00;
        if (reg_cs_ctrl_i)
            reg_d_o = {1'b0, tx_ie, rx_ie, fc_en, 1'b0, baud};
        else if (reg_cs_stat_i)
            reg_d_o = {tx_ovf, irq_o, ~cts_s2, tx_empty & (tx_state == S_IDLE),
                       rx_ferr, rx_ovf, ~tx_full, ~rx_empty};
        else if (reg_cs_data_i)
            reg_d_o = rx_empty ? 8'h00 : rx_mem[rx_rp];
    end

endmodule

// File: tb/tb_usb_uart.sv
module tb_usb_uart;
    logic       clk = 1'b0;
    logic       resetn;
    logic [7:0] reg_d_i, reg_d_o;
    logic       reg_wr_i, reg_rd_i, reg_cs_ctrl_i, reg_cs_stat_i, reg_cs_data_i;
    logic       uart_rx_i, uart_tx_o, cts_n_i, rts_n_o, irq_o;
    logic       rx_drv, loop;

    localparam int CTRL = 0, STAT = 1, DATA = 2;

    int n_cmp = 0, n_bad = 0;
    logic [7:0] v;
    int low;
    logic found;

    always #5 clk = ~clk;
    assign uart_rx_i = loop ? uart_tx_o : rx_drv;

    usb_uart #(.FIFO_AW(4)) dut (
        .clk(clk), .resetn(resetn),
        .reg_d_i(reg_d_i), .reg_d_o(reg_d_o),
        .reg_wr_i(reg_wr_i), .reg_rd_i(reg_rd_i),
        .reg_cs_ctrl_i(reg_cs_ctrl_i), .reg_cs_stat_i(reg_cs_stat_i),
        .reg_cs_data_i(reg_cs_data_i),
        .uart_rx_i(uart_rx_i), .uart_tx_o(uart_tx_o),
        .cts_n_i(cts_n_i), .rts_n_o(rts_n_o), .irq_o(irq_o)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic sel_cs(input int sel);
        reg_cs_ctrl_i = (sel == CTRL);
        reg_cs_stat_i = (sel == STAT);
        reg_cs_data_i = (sel == DATA);
    endtask

    task automatic wr(input int sel, input logic [7:0] d);
        sel_cs(sel);
        reg_d_i  = d;
        reg_wr_i = 1'b1;
        tick();
        reg_wr_i = 1'b0;
        sel_cs(-1);
    endtask

    // samples in the current cycle, then lets the (optional) pop take effect
    task automatic rd(input int sel, input logic pop, output logic [7:0] val);
        sel_cs(sel);
        reg_rd_i = pop;
        #1;
        val = reg_d_o;
        tick();
        reg_rd_i = 1'b0;
        sel_cs(-1);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop, input int div);
        rx_drv = 1'b0;
        repeat (div) tick();
        for (int i = 0; i < 8; i++) begin
            rx_drv = b[i];
            repeat (div) tick();
        end
        rx_drv = stop;
        repeat (div) tick();
        rx_drv = 1'b1;
    endtask

    task automatic wait_tx_idle(input int budget);
        logic [7:0] s;
        logic done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            rd(STAT, 1'b0, s);
            done = s[4];
        end
        check("tx_idle_wait", {7'b0, done}, 8'h01);
    endtask

    logic [9:0] pat55;

    initial begin
        resetn = 1'b0; reg_d_i = '0; reg_wr_i = 0; reg_rd_i = 0;
        reg_cs_ctrl_i = 0; reg_cs_stat_i = 0; reg_cs_data_i = 0;
        rx_drv = 1'b1; cts_n_i = 1'b1; loop = 1'b0;
        repeat (3) tick();
        resetn = 1'b1;
        tick();

        // ---- reset defaults ----
        check("rst_tx", {7'b0, uart_tx_o}, 8'h01);
        check("rst_rts", {7'b0, rts_n_o}, 8'h00);
        check("rst_irq", {7'b0, irq_o}, 8'h00);
        rd(CTRL, 1'b0, v); check("rst_ctrl", v, 8'h04);
        rd(STAT, 1'b0, v); check("rst_stat", v, 8'h12);

        // ---- 0x55 at divisor 416: start, LSB-first data, stop ----
        pat55 = {1'b1, 8'h55, 1'b0};
        wr(DATA, 8'h55);                       // now in cycle N+1
        check("tx_n1_high", {7'b0, uart_tx_o}, 8'h01);
        tick();                                // cycle N+2
        for (int i = 0; i < 10; i++) begin
            check($sformatf("tx55_bit%0d_first", i), {7'b0, uart_tx_o}, {7'b0, pat55[i]});
            repeat (415) tick();
            check($sformatf("tx55_bit%0d_last", i), {7'b0, uart_tx_o}, {7'b0, pat55[i]});
            tick();
        end

        // ---- loopback at baud 7, RX IRQ ----
        loop = 1'b1;
        wr(CTRL, 8'h27);
        wr(DATA, 8'hA5);
        wr(DATA, 8'h3C);
        repeat (1200) tick();
        check("lb_irq_rx", {7'b0, irq_o}, 8'h01);
        rd(DATA, 1'b1, v); check("lb_byte0", v, 8'hA5);
        rd(DATA, 1'b1, v); check("lb_byte1", v, 8'h3C);
        rd(STAT, 1'b0, v); check("lb_rx_empty", v & 8'h01, 8'h00);
        rd(DATA, 1'b0, v); check("lb_empty_read", v, 8'h00);
        check("lb_irq_clear", {7'b0, irq_o}, 8'h00);
        wr(CTRL, 8'h47);
        tick();
        check("tx_irq_empty", {7'b0, irq_o}, 8'h01);

        // ---- RX overflow and RTS ----
        loop = 1'b0;
        wr(CTRL, 8'h07);
        for (int i = 0; i < 17; i++) begin
            send_byte(8'h10 + 8'(i), 1'b1, 52);
            if (i == 10) check("rts_at_11", {7'b0, rts_n_o}, 8'h00);
            if (i == 11) check("rts_at_12", {7'b0, rts_n_o}, 8'h01);
            if (i == 15) begin rd(STAT, 1'b0, v); check("rx_ovf_at_16", v & 8'h04, 8'h00); end
        end
        rd(STAT, 1'b0, v); check("rx_ovf_at_17", v & 8'h04, 8'h04);
        for (int i = 0; i < 16; i++) begin
            rd(DATA, 1'b1, v);
            check($sformatf("ovf_rd%0d", i), v, 8'h10 + 8'(i));
        end
        rd(STAT, 1'b0, v); check("ovf_drained", v & 8'h01, 8'h00);
        check("rts_released", {7'b0, rts_n_o}, 8'h00);
        wr(STAT, 8'h04);
        rd(STAT, 1'b0, v); check("rx_ovf_clear", v & 8'h04, 8'h00);

        // ---- framing error, then glitch ----
        send_byte(8'h5A, 1'b0, 52);
        repeat (60) tick();
        rd(STAT, 1'b0, v); check("ferr_set", v & 8'h09, 8'h08);
        wr(STAT, 8'h08);
        rd(STAT, 1'b0, v); check("ferr_clear", v & 8'h08, 8'h00);
        rx_drv = 1'b0;
        repeat (10) tick();
        rx_drv = 1'b1;
        repeat (100) tick();
        rd(STAT, 1'b0, v); check("glitch_ignored", v & 8'h09, 8'h00);

        // ---- flow control: held, then 3 back-to-back frames ----
        wr(CTRL, 8'h17);
        wr(DATA, 8'h11); wr(DATA, 8'h22); wr(DATA, 8'h33);
        low = 0;
        for (int i = 0; i < 200; i++) begin tick(); if (!uart_tx_o) low++; end
        check("fc_held_lows", 8'(low), 8'h00);
        cts_n_i = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin tick(); found = ~uart_tx_o; end
        check("fc_release_start", {7'b0, found}, 8'h01);
        repeat (1559) tick();                  // last cycle of the third stop bit
        rd(STAT, 1'b0, v); check("fc_3frames_busy", v & 8'h10, 8'h00);
        rd(STAT, 1'b0, v); check("fc_3frames_idle", v & 8'h10, 8'h10);

        // ---- CTS dropped mid-frame ----
        wr(DATA, 8'h44);
        wr(DATA, 8'h55);                       // cycle N+2: first start bit
        check("cts_mid_start", {7'b0, uart_tx_o}, 8'h00);
        repeat (200) tick();
        cts_n_i = 1'b1;
        repeat (319) tick();
        check("cts_mid_stop", {7'b0, uart_tx_o}, 8'h01);
        low = 0;
        for (int i = 0; i < 600; i++) begin tick(); if (!uart_tx_o) low++; end
        check("cts_next_held", 8'(low), 8'h00);
        rd(STAT, 1'b0, v); check("cts_pending", v & 8'h13, 8'h02);
        cts_n_i = 1'b0;
        wait_tx_idle(800);

        // ---- flush, TX overflow, 16 frames looped back ----
        wr(CTRL, 8'h97);
        rd(CTRL, 1'b0, v); check("flush_ctrl", v, 8'h17);
        cts_n_i = 1'b1;
        loop = 1'b1;
        repeat (4) tick();
        for (int i = 0; i < 17; i++) wr(DATA, 8'h20 + 8'(i));
        rd(STAT, 1'b0, v); check("tx_ovf_stat", v, 8'h80);
        cts_n_i = 1'b0;
        wait_tx_idle(9000);
        repeat (10) tick();
        rd(STAT, 1'b0, v); check("tx16_stat", v, 8'hB3);
        check("tx16_rts", {7'b0, rts_n_o}, 8'h01);

        // ---- RX pop in the same cycle as a push into the full FIFO ----
        // stop-bit sample: 2 sync + 1 edge detect + 26 + 8*52 + 51 = 496 cycles
        loop = 1'b0;
        repeat (4) tick();
        fork
            send_byte(8'h77, 1'b1, 52);
            begin
                repeat (496) tick();
                rd(DATA, 1'b1, v);
            end
        join
        check("simul_pop_val", v, 8'h20);
        rd(STAT, 1'b0, v); check("simul_no_ovf", v & 8'h05, 8'h01);
        for (int i = 0; i < 16; i++) begin
            rd(DATA, 1'b1, v);
            check($sformatf("simul_rd%0d", i), v, (i == 15) ? 8'h77 : 8'h21 + 8'(i));
        end
        rd(STAT, 1'b0, v); check("simul_drained", v & 8'h01, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
